cp_remove: RTL and testbench

//  Receive-side cyclic-prefix stripper for the OFDM modem: consumes a continuous time-domain

---
 rtl/ofdm_rx_pkg.sv | 32 +++
 rtl/axis_skid_buffer.sv | 56 +++++
 rtl/cp_remove.sv | 169 ++++++++++++++++
 tb/tb_cp_remove.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_rx_pkg.sv
// Shared types and widths for the OFDM receive chain.
// Includes the FFT-size saturation helper used when the CP stripper takes a configuration.
package ofdm_rx_pkg;

  localparam int DATA_W        = 32;
  localparam int NFFT_LOG2_MAX = 16;
  localparam int NFFT_LOG2_MIN = 3;
  localparam int CP_W          = 16;
  localparam int SYM_W         = 16;
  localparam int CNT_W         = NFFT_LOG2_MAX + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP_CP = 2'd1,
    PASS    = 2'd2,
    DONE    = 2'd3
  } cp_state_t;

  // Clamp log2(nfft) into the supported range, then return nfft.
  function automatic logic [CNT_W-1:0] nfft_from_log2(input logic [4:0] l2);
    logic [4:0] sat;
    if (l2 < 5'(NFFT_LOG2_MIN)) begin
      sat = 5'(NFFT_LOG2_MIN);
    end else if (l2 > 5'(NFFT_LOG2_MAX)) begin
      sat = 5'(NFFT_LOG2_MAX);
    end else begin
      sat = l2;
    end
    return {{(CNT_W-1){1'b0}}, 1'b1} << sat;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-stream skid buffer: registered output, and an input ready that
// depends only on local state, so out_ready never reaches in_ready combinationally.
module axis_skid_buffer #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         empty
);

  logic [W-1:0] main_data_r;
  logic         main_valid_r;
  logic [W-1:0] skid_data_r;
  logic         skid_valid_r;
  logic         in_fire_s;

  assign in_ready  = !skid_valid_r;
  assign in_fire_s = in_valid && !skid_valid_r;
  assign out_data  = main_data_r;
  assign out_valid = main_valid_r;
  assign empty     = !main_valid_r && !skid_valid_r;

  // Output register refills from the skid entry first, then from the input.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_data_r  <= {W{1'b0}};
      main_valid_r <= 1'b0;
      skid_data_r  <= {W{1'b0}};
      skid_valid_r <= 1'b0;
    end else if (!main_valid_r || out_ready) begin
      if (skid_valid_r) begin
        main_data_r  <= skid_data_r;
        main_valid_r <= 1'b1;
        skid_valid_r <= 1'b0;
      end else if (in_fire_s) begin
        main_data_r  <= in_data;
        main_valid_r <= 1'b1;
      end else begin
        main_valid_r <= 1'b0;
      end
    end else if (in_fire_s) begin
      skid_data_r  <= in_data;
      skid_valid_r <= 1'b1;
    end else begin
      skid_valid_r <= skid_valid_r;
    end
  end

endmodule

// File: rtl/cp_remove.sv
// Receive-side cyclic-prefix stripper: drops cp_len samples per symbol and forwards
// nfft samples, tlast-framed, through a skid buffer to the FFT.
module cp_remove
  import ofdm_rx_pkg::*;
(
  input  logic              aclk,
  input  logic              areset,
  input  logic              config_start,
  input  logic              abort,
  input  logic [CP_W-1:0]   cp_len,
  input  logic [4:0]        nfft_log2,
  input  logic [SYM_W-1:0]  symbols,
  input  logic              continuous,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done,
  output logic [SYM_W-1:0]  sym_count
);

  cp_state_t         state_r, state_nx;
  logic [CP_W-1:0]   cp_len_r;
  logic [CNT_W-1:0]  nfft_m1_r;
  logic [SYM_W-1:0]  symbols_r;
  logic              cont_r;
  logic [CP_W-1:0]   skip_cnt_r;
  logic [CNT_W-1:0]  pass_cnt_r;
  logic [SYM_W-1:0]  sym_count_r;
  logic              done_r;

  logic              buf_in_ready_s;
  logic              buf_empty_s;
  logic [DATA_W:0]   buf_out_s;
  logic              s_fire_s;
  logic              m_fire_s;
  logic              skip_last_s;
  logic              pass_last_s;
  logic              finished_s;

  assign s_axis_tready = (state_r == SKIP_CP) || ((state_r == PASS) && buf_in_ready_s);
  assign s_fire_s      = s_axis_tvalid && s_axis_tready;
  assign m_fire_s      = m_axis_tvalid && m_axis_tready;
  assign skip_last_s   = (skip_cnt_r == cp_len_r - {{(CP_W-1){1'b0}}, 1'b1});
  assign pass_last_s   = (pass_cnt_r == nfft_m1_r);
  // Earlier tlast beats always leave the 2-deep stage long before the next symbol ends.
  assign finished_s    = !cont_r && (symbols_r != {SYM_W{1'b0}}) &&
                         (({1'b0, sym_count_r} + {{SYM_W{1'b0}}, 1'b1}) == {1'b0, symbols_r});

  assign busy          = (state_r != IDLE);
  assign done          = done_r;
  assign sym_count     = sym_count_r;
  assign m_axis_tdata  = buf_out_s[DATA_W-1:0];
  assign m_axis_tlast  = buf_out_s[DATA_W];

  axis_skid_buffer #(.W(DATA_W + 1)) u_out_stage (
    .clk       (aclk),
    .rst       (areset),
    .flush     (abort),
    .in_data   ({pass_last_s, s_axis_tdata}),
    .in_valid  ((state_r == PASS) && s_axis_tvalid),
    .in_ready  (buf_in_ready_s),
    .out_data  (buf_out_s),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .empty     (buf_empty_s)
  );

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic; abort overrides everything, including a coincident config_start.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (config_start) begin
          state_nx = (cp_len != {CP_W{1'b0}}) ? SKIP_CP : PASS;
        end else begin
          state_nx = IDLE;
        end
      end
      SKIP_CP: begin
        if (s_fire_s && skip_last_s) begin
          state_nx = PASS;
        end else begin
          state_nx = SKIP_CP;
        end
      end
      PASS: begin
        if (s_fire_s && pass_last_s) begin
          if (finished_s) begin
            state_nx = DONE;
          end else if (cp_len_r != {CP_W{1'b0}}) begin
            state_nx = SKIP_CP;
          end else begin
            state_nx = PASS;
          end
        end else begin
          state_nx = PASS;
        end
      end
      DONE: begin
        if (buf_empty_s) begin
          state_nx = IDLE;
        end else begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      state_nx = IDLE;
    end else begin
      state_nx = state_nx;
    end
  end

  // Configuration capture, prefix/payload counters, symbol count and done pulse.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cp_len_r    <= {CP_W{1'b0}};
      nfft_m1_r   <= {CNT_W{1'b0}};
      symbols_r   <= {SYM_W{1'b0}};
      cont_r      <= 1'b0;
      skip_cnt_r  <= {CP_W{1'b0}};
      pass_cnt_r  <= {CNT_W{1'b0}};
      sym_count_r <= {SYM_W{1'b0}};
      done_r      <= 1'b0;
    end else if (abort) begin
      skip_cnt_r  <= {CP_W{1'b0}};
      pass_cnt_r  <= {CNT_W{1'b0}};
      sym_count_r <= {SYM_W{1'b0}};
      done_r      <= 1'b0;
    end else begin
      done_r <= (state_r == DONE) && buf_empty_s;
      if (state_r == IDLE && config_start) begin
        cp_len_r    <= cp_len;
        nfft_m1_r   <= nfft_from_log2(nfft_log2) - {{(CNT_W-1){1'b0}}, 1'b1};
        symbols_r   <= symbols;
        cont_r      <= continuous;
        skip_cnt_r  <= {CP_W{1'b0}};
        pass_cnt_r  <= {CNT_W{1'b0}};
        sym_count_r <= {SYM_W{1'b0}};
      end else begin
        if (state_r == SKIP_CP && s_fire_s) begin
          skip_cnt_r <= skip_last_s ? {CP_W{1'b0}} : skip_cnt_r + {{(CP_W-1){1'b0}}, 1'b1};
        end
        if (state_r == PASS && s_fire_s) begin
          pass_cnt_r <= pass_last_s ? {CNT_W{1'b0}} : pass_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (m_fire_s && m_axis_tlast && (sym_count_r != {SYM_W{1'b1}})) begin
          sym_count_r <= sym_count_r + {{(SYM_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule

// File: tb/tb_cp_remove.sv
// Directed self-checking bench for cp_remove: framing, stalls, continuous mode,
// reset/abort mid-symbol and nfft saturation.
module tb_cp_remove;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        config_start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cp_len = 16'd0;
  logic [4:0]  nfft_log2 = 5'd3;
  logic [15:0] symbols = 16'd0;
  logic        continuous = 1'b0;
  logic [31:0] s_tdata = 32'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic        busy;
  logic        done;
  logic [15:0] sym_count;

  int checks = 0;
  int errors = 0;

  typedef struct {logic [31:0] d; logic l; int cyc;} beat_t;
  beat_t q[$];
  int    cyc = 0;
  int    done_cnt = 0;
  int    idle_cnt = 0;
  int    stall_viol = 0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_d = 32'd0;
  logic        hold_l = 1'b0;
  bit    rand_rdy = 1'b0;
  bit    rdy_lvl = 1'b1;

  always #5 aclk = ~aclk;

  cp_remove dut (
    .aclk          (aclk),
    .areset        (areset),
    .config_start  (config_start),
    .abort         (abort),
    .cp_len        (cp_len),
    .nfft_log2     (nfft_log2),
    .symbols       (symbols),
    .continuous    (continuous),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .busy          (busy),
    .done          (done),
    .sym_count     (sym_count)
  );

  always @(posedge aclk) cyc <= cyc + 1;

  // Output monitor, sampled mid-cycle when all inputs are settled.
  always @(negedge aclk) begin
    if (m_tvalid && m_tready) q.push_back('{m_tdata, m_tlast, cyc});
    if (done) done_cnt <= done_cnt + 1;
    if (!busy) idle_cnt <= idle_cnt + 1;
    if (hold_pend && !(m_tvalid && m_tdata == hold_d && m_tlast == hold_l))
      stall_viol <= stall_viol + 1;
    hold_pend <= m_tvalid && !m_tready;
    hold_d    <= m_tdata;
    hold_l    <= m_tlast;
  end

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_lvl;
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_cfg(input int cp, input int l2, input int sym, input bit cont);
    cp_len = 16'(cp); nfft_log2 = 5'(l2); symbols = 16'(sym); continuous = cont;
    config_start = 1'b1;
    @(posedge aclk); #1;
    config_start = 1'b0;
  endtask

  task automatic feed(input int start, input int n, input bit gaps, output int timeouts);
    timeouts = 0;
    for (int i = 0; i < n; i++) begin
      bit acc = 1'b0;
      int guard = 0;
      s_tdata = 32'(start + i);
      s_tvalid = 1'b1;
      while (!acc && guard < 2000) begin
        @(negedge aclk);
        acc = s_tready;
        @(posedge aclk); #1;
        guard++;
      end
      if (!acc) timeouts++;
      s_tvalid = 1'b0;
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(posedge aclk); #1;
      end
    end
  endtask

  task automatic wait_idle(output int timed_out);
    int guard = 0;
    timed_out = 1;
    while (guard < 1000) begin
      @(negedge aclk);
      if (!busy) begin
        timed_out = 0;
        break;
      end
      guard++;
    end
    @(posedge aclk); #1;
    @(posedge aclk); #1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_tvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (sym_count !== 16'd0) begin errors++; $display("FAIL reset_symcount got %0d want 0", sym_count); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", s_tready); end
    checks++; if ({m_tlast, m_tdata} !== 33'd0) begin errors++; $display("FAIL reset_data got %h want 0", {m_tlast, m_tdata}); end
    @(posedge aclk); #1;
  endtask

  task automatic test_basic(input bit stress);
    int to, wto, d0, v0;
    string nm;
    nm = stress ? "stall" : "basic";
    q.delete();
    d0 = done_cnt; v0 = stall_viol;
    rand_rdy = stress;
    start_cfg(16, 6, 3, 1'b0);
    feed(0, 240, stress, to);
    wait_idle(wto);
    rand_rdy = 1'b0;
    @(posedge aclk); #1;
    checks++; if (to + wto !== 0) begin errors++; $display("FAIL %s_timeout got %0d want 0", nm, to + wto); end
    checks++; if (q.size() !== 192) begin errors++; $display("FAIL %s_count got %0d want 192", nm, q.size()); end
    for (int k = 0; k < 192 && k < q.size(); k++) begin
      logic [31:0] ed;
      logic el;
      ed = 32'(80 * (k / 64) + 16 + (k % 64));
      el = ((k % 64) == 63);
      checks++;
      if (q[k].d !== ed || q[k].l !== el) begin
        errors++; $display("FAIL %s_beat%0d got %0d/%b want %0d/%b", nm, k, q[k].d, q[k].l, ed, el);
      end
    end
    checks++; if (sym_count !== 16'd3) begin errors++; $display("FAIL %s_symcount got %0d want 3", nm, sym_count); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL %s_done got %0d want 1", nm, done_cnt - d0); end
    if (stress) begin
      checks++; if (stall_viol - v0 !== 0) begin errors++; $display("FAIL stall_hold got %0d want 0", stall_viol - v0); end
    end
  endtask

  task automatic test_no_cp();
    int to, wto, d0;
    q.delete();
    d0 = done_cnt;
    start_cfg(0, 3, 2, 1'b0);
    feed(0, 16, 1'b0, to);
    wait_idle(wto);
    checks++; if (to + wto !== 0) begin errors++; $display("FAIL nocp_timeout got %0d want 0", to + wto); end
    checks++; if (q.size() !== 16) begin errors++; $display("FAIL nocp_count got %0d want 16", q.size()); end
    for (int k = 0; k < 16 && k < q.size(); k++) begin
      checks++;
      if (q[k].d !== 32'(k) || q[k].l !== (k == 7 || k == 15)) begin
        errors++; $display("FAIL nocp_beat%0d got %0d/%b want %0d/%b", k, q[k].d, q[k].l, k, (k == 7 || k == 15));
      end
    end
    if (q.size() == 16) begin
      checks++; if (q[15].cyc - q[0].cyc !== 15) begin errors++; $display("FAIL nocp_contig got %0d want 15", q[15].cyc - q[0].cyc); end
    end
    checks++; if (sym_count !== 16'd2) begin errors++; $display("FAIL nocp_symcount got %0d want 2", sym_count); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL nocp_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_continuous();
    int to, d0, i0, bad;
    q.delete();
    bad = 0;
    d0 = done_cnt;
    start_cfg(4, 4, 2, 1'b1);
    i0 = idle_cnt;
    feed(0, 200, 1'b0, to);
    repeat (10) @(posedge aclk);
    #1;
    checks++; if (to !== 0) begin errors++; $display("FAIL cont_timeout got %0d want 0", to); end
    checks++; if (q.size() !== 160) begin errors++; $display("FAIL cont_count got %0d want 160", q.size()); end
    for (int k = 0; k < q.size(); k++)
      if (q[k].d !== 32'(20 * (k / 16) + 4 + (k % 16)) || q[k].l !== ((k % 16) == 15)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL cont_data got %0d bad beats want 0", bad); end
    checks++; if (sym_count !== 16'd10) begin errors++; $display("FAIL cont_symcount got %0d want 10", sym_count); end
    checks++; if (busy !== 1'b1 || idle_cnt !== i0) begin errors++; $display("FAIL cont_busy got %b/%0d want 1/0", busy, idle_cnt - i0); end
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL cont_done got %0d want 0", done_cnt - d0); end
    abort = 1'b1;
    @(posedge aclk); #1;
    abort = 1'b0;
    @(negedge aclk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_abort_busy got %b want 0", busy); end
    @(posedge aclk); #1;
  endtask

  task automatic test_kill_mid(input bit use_abort);
    int to, wto, d0;
    string nm;
    nm = use_abort ? "abort" : "areset";
    start_cfg(16, 6, 3, 1'b0);
    feed(0, 114, 1'b0, to);
    rdy_lvl = 1'b0;
    feed(114, 2, 1'b0, to);
    @(negedge aclk);
    checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL %s_pre_tvalid got %b want 1", nm, m_tvalid); end
    @(posedge aclk); #1;
    if (use_abort) begin
      abort = 1'b1; config_start = 1'b1;
    end else begin
      areset = 1'b1;
    end
    @(posedge aclk); #1;
    abort = 1'b0; config_start = 1'b0; areset = 1'b0;
    @(negedge aclk);
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL %s_tvalid got %b want 0", nm, m_tvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy got %b want 0", nm, busy); end
    checks++; if (sym_count !== 16'd0) begin errors++; $display("FAIL %s_symcount got %0d want 0", nm, sym_count); end
    rdy_lvl = 1'b1;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    q.delete();
    d0 = done_cnt;
    start_cfg(16, 6, 1, 1'b0);
    feed(1000, 80, 1'b0, to);
    wait_idle(wto);
    checks++; if (q.size() !== 64) begin errors++; $display("FAIL %s_restart_count got %0d want 64", nm, q.size()); end
    for (int k = 0; k < 64 && k < q.size(); k++) begin
      checks++;
      if (q[k].d !== 32'(1016 + k) || q[k].l !== (k == 63)) begin
        errors++; $display("FAIL %s_restart_beat%0d got %0d/%b want %0d/%b", nm, k, q[k].d, q[k].l, 1016 + k, (k == 63));
      end
    end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL %s_restart_done got %0d want 1", nm, done_cnt - d0); end
  endtask

  task automatic test_abort_wins();
    abort = 1'b1; config_start = 1'b1; cp_len = 16'd4;
    @(posedge aclk); #1;
    abort = 1'b0; config_start = 1'b0;
    @(negedge aclk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_wins_busy got %b want 0", busy); end
    @(posedge aclk); #1;
  endtask

  task automatic test_nfft_sat();
    int to, wto, d0, nl, first_l, bad;
    q.delete();
    d0 = done_cnt;
    start_cfg(0, 1, 1, 1'b0);
    feed(0, 8, 1'b0, to);
    wait_idle(wto);
    checks++; if (q.size() !== 8) begin errors++; $display("FAIL sat_low_count got %0d want 8", q.size()); end
    for (int k = 0; k < 8 && k < q.size(); k++) begin
      checks++;
      if (q[k].d !== 32'(k) || q[k].l !== (k == 7)) begin
        errors++; $display("FAIL sat_low_beat%0d got %0d/%b want %0d/%b", k, q[k].d, q[k].l, k, (k == 7));
      end
    end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL sat_low_done got %0d want 1", done_cnt - d0); end
    q.delete();
    d0 = done_cnt;
    start_cfg(0, 20, 1, 1'b0);
    feed(0, 65536, 1'b0, to);
    wait_idle(wto);
    nl = 0; first_l = -1; bad = 0;
    for (int k = 0; k < q.size(); k++) begin
      if (q[k].l) begin
        nl++;
        if (first_l < 0) first_l = k;
      end
      if (q[k].d !== 32'(k)) bad++;
    end
    checks++; if (q.size() !== 65536) begin errors++; $display("FAIL sat_high_count got %0d want 65536", q.size()); end
    checks++; if (nl !== 1 || first_l !== 65535) begin errors++; $display("FAIL sat_high_tlast got %0d at %0d want 1 at 65535", nl, first_l); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL sat_high_data got %0d bad want 0", bad); end
    checks++; if (done_cnt - d0 !== 1 || to + wto !== 0) begin errors++; $display("FAIL sat_high_done got %0d/%0d want 1/0", done_cnt - d0, to + wto); end
  endtask

  initial begin
    test_reset();
    test_basic(1'b0);
    test_no_cp();
    test_basic(1'b1);
    test_continuous();
    test_kill_mid(1'b0);
    test_kill_mid(1'b1);
    test_abort_wins();
    test_nfft_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
